// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Lets NREQ requesters share one FIFO write port. Each requester asks for
//   a burst of len+1 beats. Arbitration is round-robin and takes one idle
//   cycle. Once a requester is granted, it owns the port until its whole
//   burst has been written.
//
// Ports
//   clk        single clock, shared with the FIFO write side
//   rst        synchronous active-high reset
//   req_valid  per-requester beat valid; doubles as the burst request
//   req_len    per-requester burst length minus one, LENW bits per slice
//   req_data   per-requester beat data, DSIZE bits per slice
//   req_ready  per-requester beat accept (only the granted bit can be set)
//   wfull      FIFO full flag
//   winc       FIFO write enable
//   wdata      FIFO write data
//   grant      registered one-hot grant, zero while idle
//   busy       high while a burst is in progress
//   stall_cnt  saturating count of burst cycles blocked by wfull
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int LENW  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*LENW-1:0]  req_len,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [15:0]           stall_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic [IW-1:0]   gidx, gidx_nxt;
    logic [IW-1:0]   lp, lp_nxt;
    logic [LENW-1:0] len, len_nxt;
    logic [LENW-1:0] cnt, cnt_nxt;
    logic [15:0]     stall_nxt;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic            g_valid;
    logic            xfer;

    // Round-robin search. It starts one past the last granted index and
    // wraps modulo NREQ, so the most recent winner is checked last.
    always_comb begin
        int s;
        logic [IW-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        s         = 0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            s = int'(lp) + k;
            if (s >= NREQ) s = s - NREQ;
            cand = IW'(s);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // The beat handshake is combinational with the requester. Reset
    // masks it, so a burst cut short by reset writes no further beats.
    assign g_valid   = req_valid[gidx];
    assign xfer      = (state == BURST) && g_valid && !wfull && !rst;
    assign winc      = xfer;
    assign wdata     = req_data[int'(gidx)*DSIZE +: DSIZE];
    assign req_ready = (state == BURST && !wfull && !rst) ? grant : '0;
    assign busy      = (state == BURST);

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        gidx_nxt  = gidx;
        lp_nxt    = lp;
        len_nxt   = len;
        cnt_nxt   = cnt;
        stall_nxt = stall_cnt;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt = BURST;
                    grant_nxt = NREQ'(1) << win_idx;
                    gidx_nxt  = win_idx;
                    // The length is captured here. Later changes to
                    // req_len cannot stretch or shorten this burst.
                    len_nxt   = req_len[int'(win_idx)*LENW +: LENW];
                    cnt_nxt   = '0;
                end
            end
            BURST: begin
                if (g_valid && wfull && stall_cnt != 16'hFFFF)
                    stall_nxt = stall_cnt + 16'd1;
                if (xfer) begin
                    // The compare happens before any increment. cnt
                    // therefore tops out at len, and it cannot wrap even
                    // when len is at its maximum value.
                    if (cnt == len) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        lp_nxt    = gidx;
                    end else begin
                        cnt_nxt = cnt + LENW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            gidx      <= '0;
            lp        <= IW'(NREQ - 1);
            len       <= '0;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            gidx      <= gidx_nxt;
            lp        <= lp_nxt;
            len       <= len_nxt;
            cnt       <= cnt_nxt;
            stall_cnt <= stall_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Testbench for fifo_wr_arbiter. It drives directed scenarios first and
//   then a randomized run. Every cycle it checks the DUT against a
//   transaction-level model: who owns the port and how many beats are left.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int LENW  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*LENW-1:0]  req_len;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [15:0]           stall_cnt;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .LENW(LENW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_len(req_len),
        .req_data(req_data), .req_ready(req_ready), .wfull(wfull),
        .winc(winc), .wdata(wdata), .grant(grant), .busy(busy),
        .stall_cnt(stall_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: port owner and beats still owed
    bit m_known = 1'b0;
    bit m_busy  = 1'b0;
    int m_g     = 0;
    int m_rem   = 0;
    int m_lp    = NREQ - 1;
    int m_stall = 0;

    int beats = 0;
    int gq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive the inputs, compare outputs mid-cycle, then
    // advance the model across the clock edge.
    task automatic cycle(input logic r, input logic [NREQ-1:0] v,
                         input logic [NREQ*LENW-1:0] l, input logic f);
        logic [NREQ-1:0] eg, er;
        logic            ew;
        int              idx;
        rst = r; req_valid = v; req_len = l; wfull = f; req_data = $urandom;
        #4;
        eg = m_busy ? (NREQ'(1) << m_g) : '0;
        ew = m_busy && v[m_g] && !f && !r;
        er = (m_busy && !f && !r) ? eg : '0;
        chk("winc", winc, ew);
        chk("req_ready", req_ready, er);
        chk("grant_onehot", $countones(grant) <= 1, 1);
        if (m_known) begin
            chk("grant", grant, eg);
            chk("busy", busy, m_busy);
            chk("stall_cnt", stall_cnt, m_stall);
        end
        if (ew) chk("wdata", wdata, req_data[m_g*DSIZE +: DSIZE]);
        if (winc) begin
            beats++;
            idx = -1;
            for (int i = 0; i < NREQ; i++) if (grant[i]) idx = i;
            gq.push_back(idx);
        end
        if (r) begin
            m_known = 1'b1; m_busy = 1'b0; m_lp = NREQ - 1; m_stall = 0; m_rem = 0;
        end else if (!m_busy) begin
            for (int j = 1; j <= NREQ; j++) begin
                idx = (m_lp + j) % NREQ;
                if (!m_busy && v[idx]) begin
                    m_busy = 1'b1;
                    m_g    = idx;
                    m_rem  = int'(l[idx*LENW +: LENW]) + 1;
                end
            end
        end else begin
            if (v[m_g] && f && m_stall < 65535) m_stall++;
            if (ew) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_lp   = m_g;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_scn();
        cycle(1'b1, '0, '0, 1'b0);
        beats = 0;
        gq.delete();
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_len = '0; req_data = '0; wfull = 1'b0;
        @(posedge clk);
        #1;

        // Single requester, 4-beat burst
        start_scn();
        chk("reset_grant", grant, 0);
        chk("reset_busy", busy, 0);
        chk("reset_stall", stall_cnt, 0);
        repeat (6) cycle(1'b0, 4'b0001, 16'h0003, 1'b0);
        chk("s035_beats", beats, 6 - 2);

        // All four requesting with single-beat bursts
        start_scn();
        repeat (10) cycle(1'b0, 4'b1111, 16'h0000, 1'b0);
        chk("s036_nbeats", gq.size(), 5);
        for (int k = 0; k < 5; k++) chk("s036_order", gq[k], k % NREQ);

        // wfull held high for 5 cycles in the middle of an 8-beat burst
        start_scn();
        repeat (3) cycle(1'b0, 4'b0100, 16'h0700, 1'b0);
        repeat (5) cycle(1'b0, 4'b0100, 16'h0700, 1'b1);
        repeat (6) cycle(1'b0, 4'b0100, 16'h0700, 1'b0);
        cycle(1'b0, 4'b0000, 16'h0000, 1'b0);
        chk("s037_beats", beats, 8);
        chk("s037_stall", stall_cnt, 5);

        // Maximum burst length, then check the last-granted pointer
        start_scn();
        repeat (17) cycle(1'b0, 4'b0010, 16'h00F0, 1'b0);
        chk("s038_beats", beats, 16);
        chk("s038_idle", busy, 0);
        cycle(1'b0, 4'b0110, 16'h0000, 1'b0);
        chk("s038_next_grant", grant, 4'b0100);

        // Reset arriving on the third beat
        start_scn();
        repeat (3) cycle(1'b0, 4'b0010, 16'h0070, 1'b0);
        cycle(1'b1, 4'b0010, 16'h0070, 1'b0);
        chk("s039_grant", grant, 0);
        chk("s039_busy", busy, 0);
        chk("s039_stall", stall_cnt, 0);
        cycle(1'b0, 4'b0011, 16'h0000, 1'b0);
        chk("s039_rearb", grant, 4'b0001);

        // Requester goes quiet for 3 cycles in the middle of a burst
        start_scn();
        repeat (3) cycle(1'b0, 4'b0001, 16'h0005, 1'b0);
        repeat (3) cycle(1'b0, 4'b0000, 16'h0005, 1'b0);
        chk("s040_grant_held", grant, 4'b0001);
        repeat (4) cycle(1'b0, 4'b0001, 16'h0005, 1'b0);
        cycle(1'b0, 4'b0000, 16'h0000, 1'b0);
        chk("s040_beats", beats, 6);
        chk("s040_stall", stall_cnt, 0);
        chk("s040_grant", grant, 0);

        // Randomized traffic
        start_scn();
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 199) == 0,
                  NREQ'($urandom_range(0, (1 << NREQ) - 1)),
                  (NREQ*LENW)'($urandom),
                  $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
